// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable rx oversample / tx bit strobe generator with glitch-free divisor reload.
// Define UART_BAUD_FRAC_EN to enable the fractional divisor accumulator.
module uart_baud_gen #(
    parameter int CLK_HZ       = 100000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int OVERSAMPLE   = 16,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          restart,
    output logic                          rx_tick,
    output logic                          tx_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] rx_phase,
    output logic                          load_pending,
    output logic                          load_err
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DEF_INT = DIV_W'(CLK_HZ / (DEFAULT_BAUD * OVERSAMPLE));
    logic [DIV_W:0]   cnt, n;
    logic [DIV_W-1:0] act_int, shd_int;
    logic [PW-1:0]    phase;
    logic             carry, wrap, ok_load, apply;
    assign n       = {1'b0, act_int} + {{DIV_W{1'b0}}, carry};
    assign wrap    = en && !restart && cnt == n - {{DIV_W{1'b0}}, 1'b1};
    assign ok_load = div_load && div_int >= DIV_W'(2);
    assign apply   = (restart || wrap) && load_pending;
    // Shadow is applied before a same-edge capture, so a new load always stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            phase        <= '0;
            rx_tick      <= 1'b0;
            tx_tick      <= 1'b0;
            rx_phase     <= '0;
            load_pending <= 1'b0;
            load_err     <= 1'b0;
            act_int      <= DEF_INT;
            shd_int      <= '0;
        end else begin
            rx_tick  <= wrap;
            tx_tick  <= wrap && phase == PW'(OVERSAMPLE - 1);
            load_err <= div_load && !ok_load;
            if (restart) begin
                cnt      <= '0;
                phase    <= '0;
                rx_phase <= '0;
            end else if (wrap) begin
                cnt      <= '0;
                phase    <= phase + PW'(1);
                rx_phase <= phase;
            end else if (en) begin
                cnt <= cnt + (DIV_W + 1)'(1);
            end
            if (apply) begin
                act_int      <= shd_int;
                load_pending <= 1'b0;
            end
            if (ok_load) begin
                shd_int      <= div_int;
                load_pending <= 1'b1;
            end
        end
    end
`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_W-1:0] acc, act_frac, shd_frac;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            carry    <= 1'b0;
            act_frac <= '0;
            shd_frac <= '0;
        end else begin
            if (restart)
                {carry, acc} <= '0;
            else if (wrap)
                {carry, acc} <= {1'b0, acc} + {1'b0, act_frac};
            if (apply)
                act_frac <= shd_frac;
            if (ok_load)
                shd_frac <= div_frac;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: scoreboard bench for uart_baud_gen; expected tick cycles/phases are queued by the
// stimulus and a negedge monitor pops and compares them whenever rx_tick is seen.
module tb_uart_baud_gen;
    localparam int DW = 16, FW = 4, PW = 4;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0, restart = 1'b0;
    logic [DW-1:0] div_int = '0;
    logic [FW-1:0] div_frac = '0;
    logic rx_tick, tx_tick, load_pending, load_err;
    logic [PW-1:0] rx_phase;
    int cyc = 0, checks = 0, failures = 0;
    bit mon_on = 1'b0;
    typedef struct {int c; logic tx; logic [PW-1:0] ph;} exp_t;
    exp_t sb[$];
    exp_t e_m;
    int seen[$];

    uart_baud_gen dut (
        .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
        .div_load(div_load), .restart(restart), .rx_tick(rx_tick), .tx_tick(tx_tick),
        .rx_phase(rx_phase), .load_pending(load_pending), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void push(int c, int idx);
        exp_t e;
        e.c  = c;
        e.ph = PW'(idx % 16);
        e.tx = (idx % 16) == 15;
        sb.push_back(e);
    endfunction

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (rx_tick) begin
                seen.push_back(cyc);
                if (sb.size() == 0)
                    check("rx_tick_unexpected", rx_tick, 0);
                else begin
                    e_m = sb.pop_front();
                    check("rx_tick_cycle", cyc, e_m.c);
                    check("tx_tick", tx_tick, e_m.tx);
                    check("rx_phase", rx_phase, e_m.ph);
                end
            end else begin
                if (tx_tick) check("tx_tick_without_rx", tx_tick, 0);
                if (sb.size() > 0 && sb[0].c < cyc) begin
                    e_m = sb.pop_front();
                    check("rx_tick_missed", rx_tick, 1);
                end
            end
        end
    end

    initial begin
        int r, k, b, e2, c0, k3, t, acc, c;
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_tick", rx_tick, 0);
        check("reset_tx_tick", tx_tick, 0);
        check("reset_rx_phase", rx_phase, 0);
        check("reset_load_pending", load_pending, 0);
        check("reset_load_err", load_err, 0);
        // default divisor 651: tx every 16 ticks = 10416 cycles
        r = cyc;
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) push(r + 651 * i, i - 1);
        mon_on = 1'b1;
        wait_cyc(r + 651 * 32 + 3);
        check("drain_default", sb.size(), 0);
        // int=4 then restart
        mon_on = 1'b0;
        div_int = 4;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("pending_after_load4", load_pending, 1);
        restart = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        restart = 1'b0;
        check("pending_cleared_by_restart", load_pending, 0);
        check("restart_cycle_no_tick", rx_tick, 0);
        check("restart_phase_zero", rx_phase, 0);
        sb.delete();
        seen.delete();
        for (int i = 1; i <= 21; i++) push(k + 4 * i, i - 1);
        mon_on = 1'b1;
        // reload to 10 mid-period; switch at the tick at k+84
        wait_cyc(k + 81);
        div_int = 10;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        b = k + 84;
        for (int j = 1; j <= 8; j++) push(b + 10 * j, 20 + j);
        check("pending_while_waiting", load_pending, 1);
        wait_cyc(k + 83);
        check("pending_before_tick", load_pending, 1);
        wait_cyc(k + 84);
        check("pending_cleared_at_tick", load_pending, 0);
        // rejected load
        wait_cyc(b + 22);
        div_int = 1;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("load_err_pulse", load_err, 1);
        check("rejected_not_pending", load_pending, 0);
        @(negedge clk);
        check("load_err_one_cycle", load_err, 0);
        // pending int=6, then restart together with a load of 3
        wait_cyc(b + 84);
        div_int = 6;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        check("drain_int10", sb.size(), 0);
        restart = 1'b1;
        div_load = 1'b1;
        div_int = 3;
        e2 = cyc + 1;
        @(negedge clk);
        restart = 1'b0;
        div_load = 1'b0;
        check("restart_load_pending", load_pending, 1);
        check("restart_load_no_tick", rx_tick, 0);
        c0 = e2 + 6;
        push(c0, 0);
        for (int m = 1; m <= 5; m++) push(c0 + 3 * m, m);
        for (int m = 6; m <= 20; m++) push(c0 + 3 * m + 7, m);
        wait_cyc(e2 + 5);
        check("pending_until_first_tick", load_pending, 1);
        wait_cyc(e2 + 6);
        check("pending_applied_first_tick", load_pending, 0);
        // en low for 7 edges right after tick 5
        wait_cyc(c0 + 15);
        en = 1'b0;
        wait_cyc(c0 + 19);
        check("en_low_phase_hold", rx_phase, 5);
        check("en_low_no_tick", rx_tick, 0);
        wait_cyc(c0 + 22);
        en = 1'b1;
        wait_cyc(c0 + 3 * 20 + 9);
        check("drain_en", sb.size(), 0);
        // fractional divisor 4 + 8/16
        mon_on = 1'b0;
        div_int = 4;
        div_frac = 8;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
        restart = 1'b1;
        k3 = cyc + 1;
        @(negedge clk);
        restart = 1'b0;
        sb.delete();
        seen.delete();
        t = k3;
        acc = 0;
        c = 0;
        for (int i = 1; i <= 40; i++) begin
`ifdef UART_BAUD_FRAC_EN
            t = t + 4 + c;
            c = (acc + 8) / 16;
            acc = (acc + 8) % 16;
`else
            t = t + 4;
`endif
            push(t, i - 1);
        end
        mon_on = 1'b1;
        wait_cyc(t + 3);
        check("drain_frac", sb.size(), 0);
        if (seen.size() > 20) begin
`ifdef UART_BAUD_FRAC_EN
            check("span_16_ticks", seen[20] - seen[4], 72);
`else
            check("span_16_ticks", seen[20] - seen[4], 64);
`endif
        end else
            check("frac_tick_count", seen.size(), 40);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Programmable baud-rate tick generator for the UART. It runs from the 100 MHz system clock and produces a one-cycle oversample strobe (`rx_tick`, OVERSAMPLE per bit) for the receiver and a one-cycle bit strobe (`tx_tick`) for the transmitter. The divisor is reprogrammable at run time without glitching ticks. `restart` realigns the bit phase to a detected start edge.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz
- `DEFAULT_BAUD`, 9600, baud rate loaded at reset
- `OVERSAMPLE`, 16, `rx_tick`s per bit; power of two, ≥4
- `DIV_W`, 16, width of the integer divisor
- `FRAC_W`, 4, width of the fractional divisor
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run enable; low freezes all counters
- `div_int`  in  DIV_W  integer clocks per `rx_tick`
- `div_frac`  in  FRAC_W  fractional part, in units of 1/2^FRAC_W
- `div_load`  in  1  single-cycle request to load `div_int`/`div_frac`
- `restart`  in  1  zero the divider, phase and accumulator
- `rx_tick`  out  1  oversample strobe, one cycle wide
- `tx_tick`  out  1  bit strobe, one cycle wide, coincident with an `rx_tick`
- `rx_phase`  out  log2(OVERSAMPLE)  index of the current oversample within the bit
- `load_pending`  out  1  a shadow divisor is waiting for the next period boundary
- `load_err`  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset values:
  - Active divisor int = CLK_HZ/(DEFAULT_BAUD*OVERSAMPLE), integer division (651 at defaults). Frac = 0.
  - `cnt` = 0, `phase` = 0, `acc` = 0.
  - All outputs are 0.
- Divider:
  - `cnt` counts 0..N-1. N is the active int, or int+1 when the previous period's accumulator add carried.
  - `rx_tick` is 1 in the cycle where `cnt` == N-1. In that same cycle `cnt` returns to 0.
- Fractional accumulator (only with the macro):
  - On each `rx_tick`: {carry, acc} <= acc + active frac.
  - carry=1 makes the next period N = int+1.
- Phase:
  - `phase` increments modulo OVERSAMPLE on each `rx_tick`.
  - `tx_tick` = `rx_tick` AND `phase` == OVERSAMPLE-1.
  - `rx_phase` = `phase`.
- Load:
  - `div_load` with `div_int` ≥ 2 captures the inputs into the shadow register and sets `load_pending` the next cycle.
  - `div_int` < 2 is rejected: `load_err` pulses the next cycle and the shadow register is unchanged.
  - A new load while a load is pending overwrites the shadow; the last write wins.
  - The shadow is applied at the end of a period, i.e. in an `rx_tick` cycle. The next period uses the new divisor. `load_pending` clears the same edge.
  - Loading does not reset `acc` or `phase`.
- Restart:
  - Next cycle: `cnt` = `phase` = `acc` = 0, and any pending shadow is applied at once.
  - No tick is emitted in the `restart` cycle.
  - `restart` has priority over `rx_tick` and `div_load` capture in the same cycle. A `div_load` in that cycle is still captured into the shadow, but only after the apply.
- `en` = 0:
  - `cnt`, `phase` and `acc` hold. Ticks are 0.
  - Loads are still captured. `restart` still acts.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Restart at edge k: the first `rx_tick` is in cycle k+N. The first `tx_tick` is in cycle k+N·OVERSAMPLE (integer-only case).
- Steady state, integer divisor: `rx_tick` period = N, `tx_tick` period = N·OVERSAMPLE.
- Load-to-effect latency: ≤ N+1 cycles.
- `rst` mid-period discards the shadow and pending state. Reset values return on the next edge.
- `cnt` width is DIV_W+1, so int+1 never overflows.

## Configuration
- `UART_BAUD_FRAC_EN`:
  - Defined: fractional accumulator present; `div_frac` honoured.
  - Undefined: `acc` and shadow frac are absent, `div_frac` is ignored, and N = active int always.

## Test plan
- Reset with defaults, `en`=1 → `rx_tick` every 651 cycles; `tx_tick` every 10416 cycles, coincident with `rx_phase`=15.
- Load int=4, frac=0, then `restart` → `rx_tick` every 4 cycles, `tx_tick` every 64 cycles, first `tx_tick` 64 cycles after `restart`.
- With the macro: int=4, frac=8 (FRAC_W=4) → periods alternate 4,5; 16 `rx_tick`s span 72 cycles. Without the macro: 64 cycles.
- Load int=10 while running at int=4 → `load_pending`=1 until the next `rx_tick`, then 10-cycle periods; no shortened or lengthened period at the switch.
- Load int=1 → `load_err` pulse one cycle later, `load_pending` stays 0, period unchanged. `restart` and `div_load` in the same cycle → counters zeroed, old shadow applied, new value pending.
- `en` low for 7 cycles mid-period at int=4 → ticks suppressed, the gap stretches by exactly 7 cycles, `rx_phase` is unchanged.
